// File: rtl/irq_pending_collector.sv
// Collects request edges into a maskable pending vector for a downstream priority encoder.
// Acknowledged indices are cleared, and lost events and bad acknowledges are latched as sticky flags.
module irq_pending_lane (
    input  logic clk,
    input  logic reset_n,
    input  logic i_req,
    input  logic i_clr,
    input  logic i_mask_wr,
    input  logic i_mask_in,
    input  logic i_lost_clr,
    output logic o_pend,
    output logic o_mask,
    output logic o_lost
);
    logic r_req_q, r_pend, r_mask, r_lost;
    logic w_edge;

    assign w_edge = i_req & ~r_req_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_req_q <= 1'b0;
            r_pend  <= 1'b0;
            r_mask  <= 1'b1;
            r_lost  <= 1'b0;
        end else begin
            r_req_q <= i_req;
            // A new edge beats a same-cycle clear, so the bit stays pending.
            r_pend  <= (r_pend & ~i_clr) | w_edge;
            if (i_mask_wr)
                r_mask <= i_mask_in;
            if (w_edge & r_pend & ~i_clr)
                r_lost <= 1'b1;
            else if (i_lost_clr)
                r_lost <= 1'b0;
        end
    end

    assign o_pend = r_pend;
    assign o_mask = r_mask;
    assign o_lost = r_lost;
endmodule

module irq_pending_collector #(
    parameter int N = 3,
    localparam int W = 2**N
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] req,
    input  logic         mask_wr,
    input  logic [W-1:0] mask_in,
    input  logic         svc_ack,
    input  logic [N-1:0] svc_idx,
    input  logic         lost_clr,
    output logic [W-1:0] pend_vec,
    output logic         enc_enable,
    output logic [N:0]   pend_cnt,
    output logic [W-1:0] lost,
    output logic         ack_err
);
    logic [W-1:0] w_pend, w_mask, w_clr;
    logic         w_ack_ok, w_ack_bad;
    logic         r_ack_err;
    logic [N:0]   w_cnt;

    assign pend_vec   = w_pend & w_mask;
    assign enc_enable = |pend_vec;

    // Acks are judged against the masked view; a rejected ack clears nothing.
    assign w_ack_ok  = svc_ack & enc_enable & pend_vec[svc_idx];
    assign w_ack_bad = svc_ack & ~w_ack_ok;
    assign w_clr     = w_ack_ok ? (W'(1) << svc_idx) : '0;

    for (genvar g = 0; g < W; g++) begin : g_lane
        irq_pending_lane u_lane (
            .clk       (clk),
            .reset_n   (reset_n),
            .i_req     (req[g]),
            .i_clr     (w_clr[g]),
            .i_mask_wr (mask_wr),
            .i_mask_in (mask_in[g]),
            .i_lost_clr(lost_clr),
            .o_pend    (w_pend[g]),
            .o_mask    (w_mask[g]),
            .o_lost    (lost[g])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_ack_err <= 1'b0;
        else if (w_ack_bad)
            r_ack_err <= 1'b1;
        else if (lost_clr)
            r_ack_err <= 1'b0;
    end

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < W; i++)
            w_cnt = w_cnt + (N+1)'(pend_vec[i]);
    end

    assign pend_cnt = w_cnt;
    assign ack_err  = r_ack_err;
endmodule

// File: tb/tb_irq_pending_collector.sv
// Directed bench for irq_pending_collector at N=3.
// Each scenario task drives vectors and compares against hand-computed values.
module tb_irq_pending_collector;
    localparam int N = 3;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] req;
    logic         mask_wr;
    logic [W-1:0] mask_in;
    logic         svc_ack;
    logic [N-1:0] svc_idx;
    logic         lost_clr;
    logic [W-1:0] pend_vec;
    logic         enc_enable;
    logic [N:0]   pend_cnt;
    logic [W-1:0] lost;
    logic         ack_err;

    int n_checks = 0;
    int n_errors = 0;

    irq_pending_collector #(.N(N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .mask_wr   (mask_wr),
        .mask_in   (mask_in),
        .svc_ack   (svc_ack),
        .svc_idx   (svc_idx),
        .lost_clr  (lost_clr),
        .pend_vec  (pend_vec),
        .enc_enable(enc_enable),
        .pend_cnt  (pend_cnt),
        .lost      (lost),
        .ack_err   (ack_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req = '0; mask_wr = 1'b0; mask_in = '0;
        svc_ack = 1'b0; svc_idx = '0; lost_clr = 1'b0;
        #12 reset_n = 1'b1;
        tick(); tick(); tick();
        n_checks++; if (pend_vec !== 8'h00) begin n_errors++; $display("FAIL reset_pend got %h exp 00", pend_vec); end
        n_checks++; if (enc_enable !== 1'b0) begin n_errors++; $display("FAIL reset_en got %b exp 0", enc_enable); end
        n_checks++; if (pend_cnt !== 4'd0) begin n_errors++; $display("FAIL reset_cnt got %0d exp 0", pend_cnt); end
        n_checks++; if (lost !== 8'h00 || ack_err !== 1'b0) begin n_errors++; $display("FAIL reset_flags got lost=%h err=%b exp 00/0", lost, ack_err); end
    endtask

    task automatic test_basic();
        req = 8'h24; tick(); req = '0;
        n_checks++; if (pend_vec !== 8'h24 || enc_enable !== 1'b1 || pend_cnt !== 4'd2) begin n_errors++; $display("FAIL basic_set got %h/%b/%0d exp 24/1/2", pend_vec, enc_enable, pend_cnt); end
        svc_ack = 1'b1; svc_idx = 3'd2; tick();
        n_checks++; if (pend_vec !== 8'h20 || pend_cnt !== 4'd1) begin n_errors++; $display("FAIL basic_ack2 got %h/%0d exp 20/1", pend_vec, pend_cnt); end
        svc_idx = 3'd5; tick(); svc_ack = 1'b0;
        n_checks++; if (pend_vec !== 8'h00 || enc_enable !== 1'b0) begin n_errors++; $display("FAIL basic_ack5 got %h/%b exp 00/0", pend_vec, enc_enable); end
        n_checks++; if (ack_err !== 1'b0 || lost !== 8'h00) begin n_errors++; $display("FAIL basic_flags got err=%b lost=%h exp 0/00", ack_err, lost); end
    endtask

    task automatic test_lost();
        req = 8'h08; tick(); req = '0; tick(); req = 8'h08; tick(); req = '0;
        n_checks++; if (pend_vec !== 8'h08 || lost !== 8'h08) begin n_errors++; $display("FAIL lost_set got pend=%h lost=%h exp 08/08", pend_vec, lost); end
        lost_clr = 1'b1; tick(); lost_clr = 1'b0;
        n_checks++; if (lost !== 8'h00 || pend_vec !== 8'h08) begin n_errors++; $display("FAIL lost_clr got lost=%h pend=%h exp 00/08", lost, pend_vec); end
        svc_ack = 1'b1; svc_idx = 3'd3; tick(); svc_ack = 1'b0;
        n_checks++; if (pend_vec !== 8'h00) begin n_errors++; $display("FAIL lost_drain got %h exp 00", pend_vec); end
    endtask

    task automatic test_set_wins();
        req = 8'h02; tick(); req = '0; tick();
        req = 8'h02; svc_ack = 1'b1; svc_idx = 3'd1; tick(); req = '0; svc_ack = 1'b0;
        n_checks++; if (pend_vec !== 8'h02 || lost[1] !== 1'b0) begin n_errors++; $display("FAIL set_wins got pend=%h lost=%h exp 02/00", pend_vec, lost); end
        svc_ack = 1'b1; tick(); svc_ack = 1'b0;
        n_checks++; if (pend_vec !== 8'h00 || ack_err !== 1'b0) begin n_errors++; $display("FAIL set_wins_drain got %h/%b exp 00/0", pend_vec, ack_err); end
    endtask

    task automatic test_mask();
        mask_in = 8'hF0; mask_wr = 1'b1; tick(); mask_wr = 1'b0;
        req = 8'h41; tick(); req = '0;
        n_checks++; if (pend_vec !== 8'h40 || pend_cnt !== 4'd1) begin n_errors++; $display("FAIL mask_hide got %h/%0d exp 40/1", pend_vec, pend_cnt); end
        svc_ack = 1'b1; svc_idx = 3'd0; tick(); svc_ack = 1'b0;
        n_checks++; if (ack_err !== 1'b1 || pend_vec !== 8'h40) begin n_errors++; $display("FAIL mask_ack_err got err=%b pend=%h exp 1/40", ack_err, pend_vec); end
        mask_in = 8'hFF; mask_wr = 1'b1; tick(); mask_wr = 1'b0;
        n_checks++; if (pend_vec !== 8'h41 || pend_cnt !== 4'd2) begin n_errors++; $display("FAIL mask_unhide got %h/%0d exp 41/2", pend_vec, pend_cnt); end
        svc_ack = 1'b1; svc_idx = 3'd6; tick(); svc_idx = 3'd0; tick(); svc_ack = 1'b0;
        lost_clr = 1'b1; tick(); lost_clr = 1'b0;
        n_checks++; if (pend_vec !== 8'h00 || ack_err !== 1'b0) begin n_errors++; $display("FAIL mask_drain got %h/%b exp 00/0", pend_vec, ack_err); end
    endtask

    task automatic test_ack_idle();
        svc_ack = 1'b1; svc_idx = 3'd4; tick(); svc_ack = 1'b0;
        n_checks++; if (ack_err !== 1'b1) begin n_errors++; $display("FAIL idle_ack_err got %b exp 1", ack_err); end
        // Clear and a fresh bad ack in the same cycle: the flag must stay set.
        lost_clr = 1'b1; svc_ack = 1'b1; tick(); svc_ack = 1'b0; tick(); lost_clr = 1'b0;
        n_checks++; if (ack_err !== 1'b0) begin n_errors++; $display("FAIL idle_clr got %b exp 0", ack_err); end
    endtask

    task automatic test_reset_release();
        reset_n = 1'b0; req = 8'h80; #13;
        n_checks++; if (pend_vec !== 8'h00) begin n_errors++; $display("FAIL rel_hold got %h exp 00", pend_vec); end
        reset_n = 1'b1; tick();
        n_checks++; if (pend_vec !== 8'h80 || pend_cnt !== 4'd1) begin n_errors++; $display("FAIL rel_first got %h/%0d exp 80/1", pend_vec, pend_cnt); end
        tick(); tick();
        n_checks++; if (lost !== 8'h00 || pend_vec !== 8'h80) begin n_errors++; $display("FAIL rel_held got lost=%h pend=%h exp 00/80", lost, pend_vec); end
        #2 reset_n = 1'b0; #1;
        n_checks++; if (pend_vec !== 8'h00 || enc_enable !== 1'b0 || pend_cnt !== 4'd0) begin n_errors++; $display("FAIL async_rst got %h/%b/%0d exp 00/0/0", pend_vec, enc_enable, pend_cnt); end
        req = '0; #10 reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lost();
        test_set_wins();
        test_mask();
        test_ack_idle();
        test_reset_release();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
